// File: rtl/control_elevador_3p.sv
// Request scheduler and motion sequencer for a 3-floor elevator.
// Latches floor calls, keeps travel direction while calls remain ahead, and times travel and door intervals on tick.
module control_elevador_3p #(
  parameter int unsigned T_VIAJE  = 4,
  parameter int unsigned T_PUERTA = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] btn,
  output logic [1:0] piso_actual,
  output logic       motor_sub,
  output logic       motor_baj,
  output logic       puerta_abierta,
  output logic [2:0] pendientes
);

  typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTA} estado_t;

  localparam logic [3:0] LIM_VIAJE  = 4'(T_VIAJE - 1);
  localparam logic [3:0] LIM_PUERTA = 4'(T_PUERTA - 1);

  estado_t    estado_q, estado_d;
  logic [1:0] piso_q, piso_d;
  logic [2:0] pend_q, pend_d;
  logic [3:0] timer_q, timer_d;
  logic       dir_sub_q, dir_sub_d;
  logic       motor_sub_q, motor_sub_d;
  logic       motor_baj_q, motor_baj_d;
  logic       puerta_q, puerta_d;

  function automatic logic [2:0] one_hot(input logic [1:0] p);
    case (p)
      2'd0:    one_hot = 3'b001;
      2'd1:    one_hot = 3'b010;
      2'd2:    one_hot = 3'b100;
      default: one_hot = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] sobre(input logic [1:0] p);
    case (p)
      2'd0:    sobre = 3'b110;
      2'd1:    sobre = 3'b100;
      default: sobre = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] bajo(input logic [1:0] p);
    case (p)
      2'd1:    bajo = 3'b001;
      2'd2:    bajo = 3'b011;
      default: bajo = 3'b000;
    endcase
  endfunction

  logic [2:0] piso_oh, oh_nuevo, btn_mask, pend_all;
  logic [1:0] piso_nuevo;
  logic       aqui, btn_aqui, hay_arriba, hay_abajo, viaje_fin, puerta_fin;
  logic [3:0] timer_inc;

  always_comb begin
    piso_oh    = one_hot(piso_q);
    btn_aqui   = |(btn & piso_oh);
    // Calls at the current floor are never latched while stopped there.
    btn_mask   = (estado_q == REPOSO || estado_q == PUERTA) ? (btn & ~piso_oh) : btn;
    pend_all   = pend_q | btn_mask;
    aqui       = |((btn | pend_q) & piso_oh);
    hay_arriba = |(pend_all & sobre(piso_q));
    hay_abajo  = |(pend_all & bajo(piso_q));
    viaje_fin  = tick && (timer_q == LIM_VIAJE);
    puerta_fin = tick && (timer_q == LIM_PUERTA);
    timer_inc  = tick ? (timer_q + 4'd1) : timer_q;

    estado_d   = estado_q;
    piso_d     = piso_q;
    pend_d     = pend_all;
    timer_d    = timer_inc;
    dir_sub_d  = dir_sub_q;
    piso_nuevo = piso_q;
    oh_nuevo   = piso_oh;

    case (estado_q)
      REPOSO: begin
        if (aqui) begin
          estado_d = PUERTA;
          pend_d   = pend_all & ~piso_oh;
        end else if (hay_arriba && hay_abajo) begin
          estado_d = dir_sub_q ? SUBIENDO : BAJANDO;
        end else if (hay_arriba) begin
          estado_d = SUBIENDO;
        end else if (hay_abajo) begin
          estado_d = BAJANDO;
        end
      end
      SUBIENDO: begin
        if (viaje_fin) begin
          piso_nuevo = (piso_q < 2'd2) ? (piso_q + 2'd1) : piso_q;
          oh_nuevo   = one_hot(piso_nuevo);
          piso_d     = piso_nuevo;
          dir_sub_d  = 1'b1;
          timer_d    = 4'd0;
          if (|(pend_all & oh_nuevo)) begin
            estado_d = PUERTA;
            pend_d   = pend_all & ~oh_nuevo;
          end else if (!(|(pend_all & sobre(piso_nuevo)))) begin
            estado_d = REPOSO;
          end
        end
      end
      BAJANDO: begin
        if (viaje_fin) begin
          piso_nuevo = (piso_q > 2'd0) ? (piso_q - 2'd1) : piso_q;
          oh_nuevo   = one_hot(piso_nuevo);
          piso_d     = piso_nuevo;
          dir_sub_d  = 1'b0;
          timer_d    = 4'd0;
          if (|(pend_all & oh_nuevo)) begin
            estado_d = PUERTA;
            pend_d   = pend_all & ~oh_nuevo;
          end else if (!(|(pend_all & bajo(piso_nuevo)))) begin
            estado_d = REPOSO;
          end
        end
      end
      PUERTA: begin
        pend_d = pend_all & ~piso_oh;
        // A call at this floor keeps the door open by restarting its interval.
        if (btn_aqui) begin
          timer_d = 4'd0;
        end else if (puerta_fin) begin
          estado_d = REPOSO;
        end
      end
      default: estado_d = REPOSO;
    endcase

    if (estado_d != estado_q) begin
      timer_d = 4'd0;
    end

    motor_sub_d = (estado_d == SUBIENDO);
    motor_baj_d = (estado_d == BAJANDO);
    puerta_d    = (estado_d == PUERTA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= REPOSO;
      piso_q      <= 2'd0;
      pend_q      <= 3'b000;
      timer_q     <= 4'd0;
      dir_sub_q   <= 1'b1;
      motor_sub_q <= 1'b0;
      motor_baj_q <= 1'b0;
      puerta_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      piso_q      <= piso_d;
      pend_q      <= pend_d;
      timer_q     <= timer_d;
      dir_sub_q   <= dir_sub_d;
      motor_sub_q <= motor_sub_d;
      motor_baj_q <= motor_baj_d;
      puerta_q    <= puerta_d;
    end
  end

  // Direction choice must never move the car past the end floors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (piso_q != 2'd3);
      assert (!(estado_q == SUBIENDO && piso_q == 2'd2));
      assert (!(estado_q == BAJANDO && piso_q == 2'd0));
    end
  end

  assign piso_actual    = piso_q;
  assign pendientes     = pend_q;
  assign motor_sub      = motor_sub_q;
  assign motor_baj      = motor_baj_q;
  assign puerta_abierta = puerta_q;

endmodule

// File: tb/tb_control_elevador_3p.sv
// Directed bench for the elevator controller: tick every 4 clk, T_VIAJE=4, T_PUERTA=3.
module tb_control_elevador_3p;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [2:0] btn;
  logic [1:0] piso_actual;
  logic       motor_sub;
  logic       motor_baj;
  logic       puerta_abierta;
  logic [2:0] pendientes;

  int checks;
  int errors;
  int tick_cnt;
  int fase;

  control_elevador_3p #(.T_VIAJE(4), .T_PUERTA(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .btn            (btn),
    .piso_actual    (piso_actual),
    .motor_sub      (motor_sub),
    .motor_baj      (motor_baj),
    .puerta_abierta (puerta_abierta),
    .pendientes     (pendientes)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: tick is high on every fourth edge; outputs sampled 1 time unit after the edge.
  task automatic step();
    tick = (fase == 3);
    fase = (fase + 1) % 4;
    @(posedge clk);
    #1;
    if (tick) tick_cnt++;
  endtask

  task automatic aplicar_reset();
    rst = 1'b1;
    btn = 3'b000;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic esperar_piso(input logic [1:0] p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (piso_actual == p) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic esperar_puerta(input logic v, output bit ok, output bit vio_motor);
    ok = 1'b0;
    vio_motor = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (motor_sub || motor_baj) vio_motor = 1'b1;
      if (puerta_abierta == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 3'b000;
    repeat (5) step();
    checks++;
    if ({piso_actual, pendientes, motor_sub, motor_baj, puerta_abierta} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got piso=%0d pend=%b sub=%b baj=%b door=%b exp all 0",
               piso_actual, pendientes, motor_sub, motor_baj, puerta_abierta);
    end
    rst = 1'b0;
    repeat (8) step();
    checks++;
    if ({piso_actual, pendientes, motor_sub, motor_baj, puerta_abierta} !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_reset got piso=%0d pend=%b sub=%b baj=%b door=%b exp all 0",
               piso_actual, pendientes, motor_sub, motor_baj, puerta_abierta);
    end
    $display("test_reset done");
  endtask

  task automatic test_sube_dos();
    bit ok, vm;
    int t0;
    aplicar_reset();
    btn = 3'b100;
    step();
    btn = 3'b000;
    checks++;
    if (pendientes !== 3'b100 || motor_sub !== 1'b1) begin
      errors++;
      $display("FAIL t2_start got pend=%b sub=%b exp pend=100 sub=1", pendientes, motor_sub);
    end
    t0 = tick_cnt;
    esperar_piso(2'd1, ok);
    checks++;
    if (!ok || tick_cnt - t0 != 4 || motor_sub !== 1'b1) begin
      errors++;
      $display("FAIL t2_floor1 got ok=%0b ticks=%0d sub=%b exp ok=1 ticks=4 sub=1", ok, tick_cnt - t0, motor_sub);
    end
    esperar_piso(2'd2, ok);
    checks++;
    if (!ok || tick_cnt - t0 != 8 || puerta_abierta !== 1'b1 || motor_sub !== 1'b0 || pendientes !== 3'b000) begin
      errors++;
      $display("FAIL t2_floor2 got ok=%0b ticks=%0d door=%b sub=%b pend=%b exp 1/8/1/0/000",
               ok, tick_cnt - t0, puerta_abierta, motor_sub, pendientes);
    end
    t0 = tick_cnt;
    esperar_puerta(1'b0, ok, vm);
    checks++;
    if (!ok || tick_cnt - t0 != 3 || piso_actual !== 2'd2 || motor_sub !== 1'b0 || motor_baj !== 1'b0) begin
      errors++;
      $display("FAIL t2_door got ok=%0b ticks=%0d piso=%0d sub=%b baj=%b exp 1/3/2/0/0",
               ok, tick_cnt - t0, piso_actual, motor_sub, motor_baj);
    end
    $display("test_sube_dos done");
  endtask

  task automatic test_puerta_local();
    bit ok, vm;
    int t0;
    aplicar_reset();
    btn = 3'b001;
    step();
    btn = 3'b000;
    checks++;
    if (puerta_abierta !== 1'b1 || motor_sub !== 1'b0 || motor_baj !== 1'b0 || pendientes !== 3'b000) begin
      errors++;
      $display("FAIL t3_open got door=%b sub=%b baj=%b pend=%b exp 1/0/0/000",
               puerta_abierta, motor_sub, motor_baj, pendientes);
    end
    t0 = tick_cnt;
    esperar_puerta(1'b0, ok, vm);
    repeat (8) begin
      step();
      if (motor_sub || motor_baj) vm = 1'b1;
    end
    checks++;
    if (!ok || tick_cnt - t0 - 2 != 3 || vm || piso_actual !== 2'd0) begin
      errors++;
      $display("FAIL t3_close got ok=%0b ticks=%0d motor_seen=%0b piso=%0d exp 1/3/0/0",
               ok, tick_cnt - t0 - 2, vm, piso_actual);
    end
    $display("test_puerta_local done");
  endtask

  task automatic test_parada_intermedia();
    bit ok, vm;
    int t0;
    aplicar_reset();
    btn = 3'b110;
    step();
    btn = 3'b000;
    checks++;
    if (motor_sub !== 1'b1 || pendientes !== 3'b110) begin
      errors++;
      $display("FAIL t4_start got sub=%b pend=%b exp 1/110", motor_sub, pendientes);
    end
    t0 = tick_cnt;
    esperar_piso(2'd1, ok);
    checks++;
    if (!ok || tick_cnt - t0 != 4 || puerta_abierta !== 1'b1 || motor_sub !== 1'b0 || pendientes !== 3'b100) begin
      errors++;
      $display("FAIL t4_stop1 got ok=%0b ticks=%0d door=%b sub=%b pend=%b exp 1/4/1/0/100",
               ok, tick_cnt - t0, puerta_abierta, motor_sub, pendientes);
    end
    t0 = tick_cnt;
    esperar_puerta(1'b0, ok, vm);
    checks++;
    if (!ok || tick_cnt - t0 != 3 || motor_sub !== 1'b0) begin
      errors++;
      $display("FAIL t4_door1 got ok=%0b ticks=%0d sub=%b exp 1/3/0", ok, tick_cnt - t0, motor_sub);
    end
    step();
    checks++;
    if (motor_sub !== 1'b1 || pendientes !== 3'b100) begin
      errors++;
      $display("FAIL t4_resume got sub=%b pend=%b exp 1/100", motor_sub, pendientes);
    end
    t0 = tick_cnt;
    esperar_piso(2'd2, ok);
    checks++;
    if (!ok || tick_cnt - t0 != 4 || puerta_abierta !== 1'b1 || pendientes !== 3'b000) begin
      errors++;
      $display("FAIL t4_floor2 got ok=%0b ticks=%0d door=%b pend=%b exp 1/4/1/000",
               ok, tick_cnt - t0, puerta_abierta, pendientes);
    end
    $display("test_parada_intermedia done");
  endtask

  task automatic test_inversion();
    bit ok, vm;
    int t0;
    aplicar_reset();
    btn = 3'b100;
    step();
    btn = 3'b000;
    esperar_piso(2'd1, ok);
    step();
    btn = 3'b001;
    step();
    btn = 3'b000;
    checks++;
    if (pendientes !== 3'b101 || motor_sub !== 1'b1 || piso_actual !== 2'd1) begin
      errors++;
      $display("FAIL t5_latch got pend=%b sub=%b piso=%0d exp 101/1/1", pendientes, motor_sub, piso_actual);
    end
    esperar_piso(2'd2, ok);
    checks++;
    if (!ok || puerta_abierta !== 1'b1 || pendientes !== 3'b001) begin
      errors++;
      $display("FAIL t5_top got ok=%0b door=%b pend=%b exp 1/1/001", ok, puerta_abierta, pendientes);
    end
    t0 = tick_cnt;
    esperar_puerta(1'b0, ok, vm);
    step();
    checks++;
    if (!ok || motor_baj !== 1'b1 || motor_sub !== 1'b0) begin
      errors++;
      $display("FAIL t5_reverse got ok=%0b baj=%b sub=%b exp 1/1/0", ok, motor_baj, motor_sub);
    end
    t0 = tick_cnt;
    esperar_piso(2'd1, ok);
    checks++;
    if (!ok || tick_cnt - t0 != 4 || motor_baj !== 1'b1 || puerta_abierta !== 1'b0) begin
      errors++;
      $display("FAIL t5_pass1 got ok=%0b ticks=%0d baj=%b door=%b exp 1/4/1/0",
               ok, tick_cnt - t0, motor_baj, puerta_abierta);
    end
    esperar_piso(2'd0, ok);
    checks++;
    if (!ok || tick_cnt - t0 != 8 || puerta_abierta !== 1'b1 || motor_baj !== 1'b0 || pendientes !== 3'b000) begin
      errors++;
      $display("FAIL t5_floor0 got ok=%0b ticks=%0d door=%b baj=%b pend=%b exp 1/8/1/0/000",
               ok, tick_cnt - t0, puerta_abierta, motor_baj, pendientes);
    end
    $display("test_inversion done");
  endtask

  task automatic test_reset_medio();
    bit ok, vm;
    int t0;
    aplicar_reset();
    btn = 3'b100;
    step();
    btn = 3'b000;
    t0 = tick_cnt;
    for (int i = 0; i < 50 && tick_cnt - t0 < 2; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if ({piso_actual, pendientes, motor_sub, motor_baj, puerta_abierta} !== 8'h00) begin
      errors++;
      $display("FAIL t6_midreset got piso=%0d pend=%b sub=%b baj=%b door=%b exp all 0",
               piso_actual, pendientes, motor_sub, motor_baj, puerta_abierta);
    end
    rst = 1'b0;
    btn = 3'b001;
    step();
    repeat (20) step();
    checks++;
    if (puerta_abierta !== 1'b1 || pendientes !== 3'b000) begin
      errors++;
      $display("FAIL t6_held got door=%b pend=%b exp 1/000", puerta_abierta, pendientes);
    end
    t0 = tick_cnt;
    btn = 3'b000;
    esperar_puerta(1'b0, ok, vm);
    checks++;
    if (!ok || tick_cnt - t0 != 3 || vm) begin
      errors++;
      $display("FAIL t6_release got ok=%0b ticks=%0d motor_seen=%0b exp 1/3/0", ok, tick_cnt - t0, vm);
    end
    $display("test_reset_medio done");
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    tick_cnt = 0;
    fase     = 0;
    tick     = 1'b0;
    btn      = 3'b000;
    rst      = 1'b1;
    test_reset();
    test_sube_dos();
    test_puerta_local();
    test_parada_intermedia();
    test_inversion();
    test_reset_medio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
